// File: rtl/clause_walker.sv
// ---------------------------------------------------------------------------
// clause_walker
//
// Walks the clause table from slot 0 up to the last filled slot. Each stored
// clause index is forwarded to the clause evaluator over a valid/ready
// handshake. When the walk ends, the block pulses done and reports how many
// clauses the evaluator accepted.
//
// The end of the list is normally signalled by the table's error flag, which
// is raised when the index is at or past the fill pointer. A full table has a
// wrapped pointer, so every read reports error. In that case error is
// ignored and the walk stops after the last slot.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-low reset
//   start       begin a walk (honoured only when idle)
//   abort       drop the walk on the next edge; no done pulse
//   tbl_full    table full flag
//   tbl_error   table error for the current read (combinational)
//   tbl_clause  table clause_index_out for the current read (combinational)
//   tbl_read    table read strobe (high only in READ)
//   tbl_index   table slot being addressed (always the walk index)
//   out_valid   out_clause holds a clause for the evaluator
//   out_clause  registered clause index
//   out_ready   evaluator accepts on out_valid & out_ready
//   busy        high in every state except IDLE
//   done        one-cycle pulse on normal completion
//   count       clauses accepted in the current or last walk
// ---------------------------------------------------------------------------
`ifndef CLAUSE_TABLE_BITS
`define CLAUSE_TABLE_BITS 3
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

module clause_walker #(
    parameter int CLAUSE_TABLE_BITS = `CLAUSE_TABLE_BITS,
    parameter int MAX_CLAUSES_BITS  = `MAX_CLAUSES_BITS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         tbl_full,
    input  logic                         tbl_error,
    input  logic [MAX_CLAUSES_BITS-1:0]  tbl_clause,
    output logic                         tbl_read,
    output logic [CLAUSE_TABLE_BITS-1:0] tbl_index,
    output logic                         out_valid,
    output logic [MAX_CLAUSES_BITS-1:0]  out_clause,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic [CLAUSE_TABLE_BITS:0]   count
);

    localparam logic [CLAUSE_TABLE_BITS-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                       state;
    logic [CLAUSE_TABLE_BITS-1:0] idx;

    // The table is addressed by the walk index in every state, so the value
    // presented in READ is already stable when the state is entered.
    assign tbl_index = idx;

    // All outputs are registered. Each transition sets the values that
    // belong to the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            count      <= '0;
            out_clause <= '0;
            out_valid  <= 1'b0;
            tbl_read   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            // Abort wins over everything, including a same-cycle acceptance.
            // count is left holding what was accepted before this cycle.
            state     <= IDLE;
            out_valid <= 1'b0;
            tbl_read  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= READ;
                        idx      <= '0;
                        count    <= '0;
                        tbl_read <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                READ: begin
                    tbl_read <= 1'b0;
                    // A full table reports error on every slot, so error
                    // means "end of list" only when the table is not full.
                    if (tbl_error && !tbl_full) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        out_clause <= tbl_clause;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end

                HOLD: begin
                    if (out_ready) begin
                        count     <= count + 1'b1;
                        out_valid <= 1'b0;
                        // The last-slot check comes before the increment,
                        // so idx never wraps.
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            idx      <= idx + 1'b1;
                            state    <= READ;
                            tbl_read <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    tbl_read  <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/clause_walker.md
# clause_walker

Sequential scanner that sits directly downstream of the clause table. On `start` it reads the table's stored clause indices in order, from slot 0 up to the last filled slot. It forwards each clause index to the clause evaluator over a valid/ready handshake, then reports completion and the number of clauses emitted. It owns the table's `read`/`index_in` port during a walk. It uses the table's `error` (index ≥ fill pointer) and `full` flags to detect the end of the list.

## Interface
Parameters:
- `CLAUSE_TABLE_BITS`, default `` `CLAUSE_TABLE_BITS ``: slot index width; table size is 2^CLAUSE_TABLE_BITS.
- `MAX_CLAUSES_BITS`, default `` `MAX_CLAUSES_BITS ``: clause index width.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a walk; sampled only in IDLE.
- `abort`  in  1  terminate the walk immediately; no `done` pulse.
- `tbl_full`  in  1  table `full` flag.
- `tbl_error`  in  1  table `error`; combinational response to the same-cycle read.
- `tbl_clause`  in  MAX_CLAUSES_BITS  table `clause_index_out`; combinational.
- `tbl_read`  out  1  table read strobe.
- `tbl_index`  out  CLAUSE_TABLE_BITS  table slot being read.
- `out_valid`  out  1  `out_clause` holds a clause for the evaluator.
- `out_clause`  out  MAX_CLAUSES_BITS  registered clause index.
- `out_ready`  in  1  evaluator accepts when `out_valid` & `out_ready`.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse when a walk completes normally.
- `count`  out  CLAUSE_TABLE_BITS+1  clauses accepted by the evaluator in the current or last walk.

## Operation
- States: IDLE, READ, HOLD, DONE.
- IDLE
  - `start` → READ. Clear `idx` and `count` to 0.
  - `start` in any other state is ignored.
- READ
  - Drive `tbl_read`=1 and `tbl_index`=`idx`.
  - If `tbl_error` & !`tbl_full` → DONE; no output is produced.
  - Otherwise register `tbl_clause` into `out_clause`, set `out_valid`, → HOLD.
- HOLD
  - `out_valid` stays high and `out_clause` stays stable until `out_ready`.
  - On acceptance, `count`++ and `out_valid` drops.
  - If `idx` == 2^CLAUSE_TABLE_BITS−1 → DONE; else `idx`++ → READ.
- DONE
  - `done`=1 for exactly one cycle, then → IDLE.
  - `count` holds its value until the next `start`.
- Full table:
  - When full, the table pointer has wrapped to 0, so every read reports `tbl_error`.
  - While `tbl_full`=1 the walker ignores `tbl_error` and visits all 2^CLAUSE_TABLE_BITS slots.
  - Termination is by the last-index check only.
- `abort` (any state) → IDLE on the next edge.
  - `out_valid` drops and `done` is not pulsed.
  - `count` retains the number accepted so far.
  - `abort` has priority over every other transition, including acceptance in the same cycle; that clause is not counted.
- `tbl_read` is 0 outside READ. `tbl_index` is `idx` at all times.
- `idx` is CLAUSE_TABLE_BITS wide; it never wraps because the last-index check precedes any increment.
- `count` saturates naturally: its maximum is 2^CLAUSE_TABLE_BITS, which fits in CLAUSE_TABLE_BITS+1 bits.

## Timing
- Reset (asynchronous, on `reset`=0):
  - State IDLE.
  - `idx`, `count`, and `out_clause` = 0.
  - `out_valid`, `busy`, `done`, `tbl_read` = 0.
- Reset asserted mid-walk takes effect immediately, without waiting for a clock edge. The walk is lost; no `done` pulse.
- `start` at edge N:
  - READ in cycle N+1.
  - With `out_ready` held high, the first `out_valid` is in cycle N+2.
- Throughput: one clause per 2 cycles (READ, HOLD) with `out_ready` high; each stall cycle adds 1.
- Empty table: `start` at N, READ at N+1, `done` at N+2, IDLE at N+3.
- `busy` is high from N+1 through the DONE cycle inclusive.
- `tbl_error`/`tbl_clause` are sampled in the same READ cycle; no table read latency is assumed.

## Test plan
- Empty table (`tbl_error`=1 at idx 0, `tbl_full`=0): pulse `start` → `done` 2 cycles later, `count`=0, `out_valid` never high.
- Table holding {5, 9, 2}, `out_ready`=1 → `out_clause` 5, 9, 2 on cycles N+2, N+4, N+6; read at idx 3 errors; `done` at N+8; `count`=3.
- Backpressure: same table, `out_ready` low for 4 cycles while 9 is presented → `out_clause`=9 and `out_valid`=1 stable for those cycles; no read at idx 2 until accepted; final `count`=3.
- Full table (CLAUSE_TABLE_BITS=3, 8 entries 10..17, `tbl_full`=1, `tbl_error`=1 throughout) → all 8 values emitted in order, `done` pulsed, `count`=8, last `tbl_index`=7.
- `abort` asserted in HOLD after 2 accepted clauses → IDLE next cycle, `out_valid`=0, no `done`, `count`=2; a subsequent `start` restarts at idx 0 and `count` clears.
- Async reset low mid-HOLD, between clock edges → all outputs 0 immediately; `start` ignored while `reset`=0; normal walk after release.
